// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush vectors, exception inputs and redirect handshake between pipeline and pipe_ctrl
interface pipe_ctrl_if #(parameter int NSTAGE = 5, parameter int ADDR_W = 32);
  logic [NSTAGE-1:0] stallreq;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic              exc_flag;
  logic [4:0]        exc_type;
  logic [31:0]       cp0_Status;
  logic [31:0]       cp0_Cause;
  logic [31:0]       cp0_EPC;
  logic [31:0]       cp0_ErrorEPC;
  logic [31:0]       cp0_EBase;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_ack;
  logic              wdog_trip;
  modport master (
    output stallreq, exc_flag, exc_type, cp0_Status, cp0_Cause, cp0_EPC, cp0_ErrorEPC, cp0_EBase, redir_ack,
    input  stall, flush, redir_valid, redir_pc, wdog_trip
  );
  modport slave (
    input  stallreq, exc_flag, exc_type, cp0_Status, cp0_Cause, cp0_EPC, cp0_ErrorEPC, cp0_EBase, redir_ack,
    output stall, flush, redir_valid, redir_pc, wdog_trip
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush resolution plus registered exception/ERET redirect with valid/ack handshake.
// Optional stall watchdog built when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl #(
  parameter int NSTAGE  = 5,
  parameter int IF_SPAN = 3,
  parameter int ADDR_W  = 32,
  parameter int WDOG_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   i_bus
);
  localparam logic [4:0] EXCT_INTR = 5'd1;
  localparam logic [4:0] EXCT_CPU  = 5'd2;
  localparam logic [4:0] EXCT_RI   = 5'd3;
  localparam logic [4:0] EXCT_OV   = 5'd4;
  localparam logic [4:0] EXCT_TRAP = 5'd5;
  localparam logic [4:0] EXCT_SYSC = 5'd6;
  localparam logic [4:0] EXCT_BP   = 5'd7;
  localparam logic [4:0] EXCT_ADE  = 5'd8;
  localparam logic [4:0] EXCT_TLBR = 5'd9;
  localparam logic [4:0] EXCT_TLBI = 5'd10;
  localparam logic [4:0] EXCT_TLBM = 5'd11;
  localparam logic [4:0] EXCT_ERET = 5'd12;
  logic [NSTAGE-1:0] w_hold, w_bub;
  logic [ADDR_W-1:0] w_base, w_off, w_tgt;
  logic              w_ok, w_kill;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  // A stage holds when it or any later stage requests; an IF request also holds the whole IF span.
  always_comb begin
    w_hold = '0;
    w_bub  = '0;
    for (int k = 0; k < NSTAGE; k++)
      w_hold[k] = (|(i_bus.stallreq >> k)) || (i_bus.stallreq[0] && k < IF_SPAN);
    for (int k = 1; k < NSTAGE; k++)
      w_bub[k] = w_hold[k-1] && !w_hold[k];
  end
  assign w_kill      = rst || i_bus.exc_flag;
  assign i_bus.stall = w_kill ? '0 : w_hold | NSTAGE'(r_valid);
  assign i_bus.flush = w_kill ? '1 : w_bub;
  always_comb begin
    w_base = i_bus.cp0_Status[22] ? ADDR_W'(32'hBFC0_0200) : ADDR_W'({i_bus.cp0_EBase[31:12], 12'h000});
    w_off  = i_bus.exc_type == EXCT_INTR ? ADDR_W'(i_bus.cp0_Cause[23] ? 12'h200 : 12'h180) :
             i_bus.exc_type == EXCT_TLBR ? ADDR_W'(i_bus.cp0_Status[1] ? 12'h180 : 12'h000) :
                                           ADDR_W'(12'h180);
    w_tgt  = i_bus.exc_type == EXCT_ERET ?
             ADDR_W'(i_bus.cp0_Status[2] ? i_bus.cp0_ErrorEPC : i_bus.cp0_EPC) : w_base + w_off;
    w_ok   = i_bus.exc_type inside {EXCT_INTR, EXCT_CPU, EXCT_RI, EXCT_OV, EXCT_TRAP, EXCT_SYSC,
                                    EXCT_BP, EXCT_ADE, EXCT_TLBR, EXCT_TLBI, EXCT_TLBM, EXCT_ERET};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (i_bus.exc_flag && w_ok) begin
      r_valid <= 1'b1;
      r_pc    <= w_tgt;
    end else if (r_valid && i_bus.redir_ack) begin
      r_valid <= 1'b0;
    end
  end
  assign i_bus.redir_valid = r_valid;
  assign i_bus.redir_pc    = r_pc;
`ifdef PIPE_CTRL_WDOG_EN
  logic [WDOG_W-1:0] r_wcnt, w_wnxt;
  logic              r_trip;
  assign w_wnxt = (|i_bus.stallreq && !i_bus.exc_flag) ? (&r_wcnt ? r_wcnt : r_wcnt + 1'b1) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
      r_trip <= 1'b0;
    end else begin
      r_wcnt <= w_wnxt;
      r_trip <= r_trip || &w_wnxt;
    end
  end
  assign i_bus.wdog_trip = r_trip;
`else
  assign i_bus.wdog_trip = WDOG_W < 0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven stall/flush vectors plus directed redirect, reset and watchdog sequences
module tb_pipe_ctrl;
  localparam logic [4:0] T_NONE = 5'd0, T_INTR = 5'd1, T_RI = 5'd3, T_SYSC = 5'd6, T_BP = 5'd7,
                         T_TLBR = 5'd9, T_ERET = 5'd12, T_BAD = 5'd20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  pipe_ctrl_if #(.NSTAGE(5), .ADDR_W(32)) bus ();
  pipe_ctrl #(.NSTAGE(5), .IF_SPAN(3), .ADDR_W(32), .WDOG_W(4)) dut (.clk(clk), .rst(rst), .i_bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] req;
    logic [4:0] stall;
    logic [4:0] flush;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic raise(input logic [4:0] t, input logic [31:0] st, input logic [31:0] ca, input logic [31:0] eb);
    bus.exc_flag   = 1'b1;
    bus.exc_type   = t;
    bus.cp0_Status = st;
    bus.cp0_Cause  = ca;
    bus.cp0_EBase  = eb;
  endtask
  task automatic take();
    bus.redir_ack = 1'b1;
    tick();
    bus.redir_ack = 1'b0;
  endtask
  initial begin
    vt[0] = '{5'b00000, 5'b00000, 5'b00000};
    vt[1] = '{5'b00010, 5'b00011, 5'b00100};
    vt[2] = '{5'b00101, 5'b00111, 5'b01000};
    vt[3] = '{5'b10000, 5'b11111, 5'b00000};
    vt[4] = '{5'b00001, 5'b00111, 5'b01000};
    vt[5] = '{5'b01001, 5'b01111, 5'b10000};
    vt[6] = '{5'b00100, 5'b00111, 5'b01000};
    vt[7] = '{5'b01000, 5'b01111, 5'b10000};
    bus.stallreq = '0; bus.exc_flag = 1'b0; bus.exc_type = T_NONE; bus.redir_ack = 1'b0;
    bus.cp0_Status = '0; bus.cp0_Cause = '0; bus.cp0_EPC = '0; bus.cp0_ErrorEPC = '0; bus.cp0_EBase = '0;
    tick();
    tick();
    chk("rst_stall", bus.stall, 5'b00000);
    chk("rst_flush", bus.flush, 5'b11111);
    chk("rst_valid", bus.redir_valid, 1'b0);
    chk("rst_pc", bus.redir_pc, 32'h0);
    chk("rst_wdog", bus.wdog_trip, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.stallreq = vt[i].req;
      #1;
      chk($sformatf("vec%0d_stall", i), bus.stall, vt[i].stall);
      chk($sformatf("vec%0d_flush", i), bus.flush, vt[i].flush);
      tick();
    end
    bus.stallreq = 5'b01000;
    raise(T_SYSC, 32'h0, 32'h0, 32'h8000_1000);
    #1;
    chk("exc_stall", bus.stall, 5'b00000);
    chk("exc_flush", bus.flush, 5'b11111);
    tick();
    bus.exc_flag = 1'b0;
    bus.stallreq = '0;
    #1;
    chk("sysc_valid", bus.redir_valid, 1'b1);
    chk("sysc_pc", bus.redir_pc, 32'h8000_1180);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", bus.redir_valid, 1'b1);
      chk("hold_pc", bus.redir_pc, 32'h8000_1180);
      chk("hold_stall0", bus.stall, 5'b00001);
    end
    take();
    chk("ack_valid", bus.redir_valid, 1'b0);
    chk("ack_stall", bus.stall, 5'b00000);
    raise(T_INTR, 32'h0040_0000, 32'h0080_0000, 32'h0);
    tick();
    bus.exc_flag = 1'b0;
    chk("intr_pc", bus.redir_pc, 32'hBFC0_0400);
    take();
    raise(T_TLBR, 32'h0, 32'h0, 32'h8000_0000);
    tick();
    bus.exc_flag = 1'b0;
    chk("tlbr_pc", bus.redir_pc, 32'h8000_0000);
    take();
    raise(T_TLBR, 32'h2, 32'h0, 32'h8000_0000);
    tick();
    bus.exc_flag = 1'b0;
    chk("tlbr_exl_pc", bus.redir_pc, 32'h8000_0180);
    take();
    bus.cp0_ErrorEPC = 32'hBFC0_1234;
    bus.cp0_EPC      = 32'h8000_4444;
    raise(T_ERET, 32'h4, 32'h0, 32'h0);
    tick();
    bus.exc_flag = 1'b0;
    chk("eret_erl_pc", bus.redir_pc, 32'hBFC0_1234);
    raise(T_RI, 32'h0, 32'h0, 32'h8000_2000);
    bus.redir_ack = 1'b1;
    tick();
    bus.exc_flag = 1'b0;
    bus.redir_ack = 1'b0;
    chk("ackexc_valid", bus.redir_valid, 1'b1);
    chk("ackexc_pc", bus.redir_pc, 32'h8000_2180);
    raise(T_ERET, 32'h0, 32'h0, 32'h0);
    tick();
    bus.exc_flag = 1'b0;
    chk("overwrite_pc", bus.redir_pc, 32'h8000_4444);
    take();
    chk("cleared_valid", bus.redir_valid, 1'b0);
    bus.redir_ack = 1'b1;
    tick();
    bus.redir_ack = 1'b0;
    chk("stray_ack_valid", bus.redir_valid, 1'b0);
    raise(T_BAD, 32'h0, 32'h0, 32'h0);
    #1;
    chk("bad_flush", bus.flush, 5'b11111);
    tick();
    bus.exc_flag = 1'b0;
    chk("bad_valid", bus.redir_valid, 1'b0);
    raise(T_BP, 32'h0, 32'h0, 32'h8000_3000);
    tick();
    bus.exc_flag = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstpend_stall", bus.stall, 5'b00000);
    chk("rstpend_flush", bus.flush, 5'b11111);
    tick();
    rst = 1'b0;
    chk("rstpend_valid", bus.redir_valid, 1'b0);
    chk("rstpend_pc", bus.redir_pc, 32'h0);
    bus.stallreq = 5'b00100;
    for (int i = 0; i < 10; i++) tick();
    bus.stallreq = '0;
    tick();
    bus.stallreq = 5'b00100;
    for (int i = 0; i < 10; i++) tick();
    chk("wdog_clear", bus.wdog_trip, 1'b0);
    bus.stallreq = '0;
    tick();
    bus.stallreq = 5'b00100;
    for (int i = 0; i < 14; i++) tick();
    chk("wdog_14", bus.wdog_trip, 1'b0);
    tick();
`ifdef PIPE_CTRL_WDOG_EN
    chk("wdog_15", bus.wdog_trip, 1'b1);
    bus.stallreq = '0;
    tick();
    tick();
    chk("wdog_sticky", bus.wdog_trip, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wdog_rst", bus.wdog_trip, 1'b0);
`else
    for (int i = 0; i < 5; i++) tick();
    chk("wdog_off", bus.wdog_trip, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
